retospect_clockbox_v2: RTL and testbench
========================================

Name: retospect_clockbox_v2

Overview:
Parametrised successor of the neurochip decay clock generator. Produces N_CH independent programmable periodic tick strobes plus the constant "never" and "always" decay lines on a shared clockbus consumed by the CNB array. Configuration arrives on the bit-serial config chain into a shadow register and is committed atomically when config_en drops. Counters therefore never run on half-shifted values.

Parameters:
N_CH, 6, number of programmable tick channels; clockbus width is N_CH+2
CNT_W, 8, period/counter width per channel
PRE_W, 4, prescaler width (used only with RETOSPECT_CLK_PRESCALE_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
config_en  in  1  high = shift config chain; falling edge commits shadow to active
bs_in  in  1  serial config in
bs_out  out  1  serial config out, to the first CNB
reset_nn  in  1  synchronous network reset, clears counters only
clockbus  out  N_CH+2  [0]=0, [1]=1, [k+2]=tick of channel k
active_en  out  N_CH  committed enable bit per channel

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Async reset (rst_n=0) clears everything: shadow, active, counters, cfg_q and prescaler to 0. As a result bs_out=0, active_en=0 and clockbus={N_CH zeros,1,0}.
- Channel config word is {en, period[CNT_W-1:0]}, CNT_W+1 bits. The chain holds N_CH words, channel 0 first. Chain length L = N_CH*(CNT_W+1) (54 at defaults).
- Shift, when config_en=1 and reset_nn=0: the whole chain shifts right by one each cycle.
  - bs_in enters the MSB (en) of channel 0.
  - The LSB of channel k feeds the MSB of channel k+1.
  - bs_out is the registered LSB of the last word.
- cfg_q is a register holding config_en delayed one cycle.
- Commit occurs on the cycle where cfg_q=1 and config_en=0:
  - active <= shadow.
  - All counters <= 0.
- The active config changes only at commit or rst_n.
- Counter k, in a non-shift, non-reset_nn cycle:
  - If active_en[k]=0, count <= 0.
  - Else count <= (count==period) ? 0 : count+1.
  - This gives a period of period+1 cycles with no overflow; period=2^CNT_W-1 wraps cleanly.
- Tick, combinational from registers: clockbus[k+2] = active_en[k] & (count_k==period_k) & ~config_en.
- While config_en=1, counters hold and all programmable ticks are 0. clockbus[1:0] stays 2'b10 at all times.
- reset_nn=1, priority rst_n > reset_nn > config_en:
  - Counters <= 0 and no shift occurs.
  - cfg_q still updates.
  - A commit edge coinciding with reset_nn still commits.
- Latency:
  - After commit cycle E, count=0 at E+1, so a tick is first visible in cycle E+1+period.
  - A period=0 channel ticks on every cycle from E+1.
- rst_n asserted mid-shift or mid-count: immediate clear. After release, no commit happens until a full shift/falling edge sequence.

Optional Feature:
RETOSPECT_CLK_PRESCALE_EN
- Defined:
  - A PRE_W-bit prescale word is appended to the chain after channel N_CH-1, making L = N_CH*(CNT_W+1)+PRE_W. bs_out is then the prescale LSB.
  - The word is committed with the rest.
  - A global prescaler counts 0..pre the same way a channel counter does. Channel counters advance only on prescaler wrap cycles.
  - A tick is asserted only on the prescaler wrap cycle, so the tick period is (period+1)*(pre+1).
  - reset_nn and commit also clear the prescaler.
- Undefined: there is no prescaler, counters advance every cycle, and L is as above.

Test Plan:
1. Reset check: rst_n=0 while counting -> immediately clockbus=8'b00000010, bs_out=0, active_en=0; after release no ticks.
2. Single channel: shift 54 bits so ch0={1,8'd3} and the rest are 0, then drop config_en at edge E -> clockbus[2] high at E+4, E+8, E+12; clockbus[7:3]=0.
3. Boundary periods: ch1={1,0} -> clockbus[3]=1 every cycle after E+1. ch2={1,255} -> ticks exactly 256 cycles apart over 3 periods.
4. Chain passthrough: with an arbitrary active config, shift a 70-bit pattern -> bs_out equals bs_in delayed 54 cycles. active_en and tick periods are unchanged until the falling edge, and programmable ticks are 0 throughout the shift.
5. reset_nn: pulse reset_nn for 1 cycle at count=2 of a period-3 channel -> next tick exactly 4 cycles after the pulse. A pulse concurrent with config_en=1 suppresses that shift (bs_out sequence delayed one cycle).
6. With RETOSPECT_CLK_PRESCALE_EN, pre=2 and ch0 period=1 -> clockbus[2] ticks every 6 cycles; L=58 verified via bs_out delay.

Source files
------------

// File: rtl/retospect_clockbox_v2.sv
// -----------------------------------------------------------------------------
// retospect_clockbox_v2
//
// Decay clock generator for the CNB array. It drives N_CH programmable
// periodic tick strobes plus the constant "never" (bit 0) and "always" (bit 1)
// decay lines onto a shared clockbus.
//
// Configuration is shifted in bit-serially into a shadow chain while config_en
// is high. When config_en falls, the shadow is committed to the active
// register and all counters restart. This means the counters never run on a
// half-shifted configuration.
//
// Chain layout (bs_in end first):
//   ch0 {en, period[CNT_W-1:0]}, ch1 {...}, ..., ch(N_CH-1) {...}
//   [, prescale[PRE_W-1:0]]
// bs_out is the last bit of the chain and feeds the first CNB.
//
// Optional feature, compile-time macro RETOSPECT_CLK_PRESCALE_EN:
//   - Appends a PRE_W-bit prescale word to the end of the chain.
//   - A global prescaler counts from 0 to pre.
//   - Channel counters advance only when the prescaler wraps.
//   - Ticks are qualified with the prescaler wrap.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset; clears all state
//   config_en  1 = shift the config chain; a falling edge commits it
//   bs_in      serial config input
//   bs_out     serial config output (last bit of the chain)
//   reset_nn   synchronous network reset; clears counters only
//   clockbus   [0]=0, [1]=1, [k+2]=tick of channel k
//   active_en  committed enable bit per channel
// -----------------------------------------------------------------------------
module retospect_clockbox_v2 #(
  parameter int N_CH  = 6,
  parameter int CNT_W = 8,
  parameter int PRE_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            config_en,
  input  logic            bs_in,
  output logic            bs_out,
  input  logic            reset_nn,
  output logic [N_CH+1:0] clockbus,
  output logic [N_CH-1:0] active_en
);

  localparam int WORD_W = CNT_W + 1;
`ifdef RETOSPECT_CLK_PRESCALE_EN
  localparam bit PRESCALE = 1'b1;
`else
  localparam bit PRESCALE = 1'b0;
`endif
  localparam int CHAIN_L = N_CH * WORD_W + (PRESCALE ? PRE_W : 0);

  logic [CHAIN_L-1:0]          shadow_q, shadow_d;
  logic [CHAIN_L-1:0]          active_q, active_d;
  logic                        cfg_q, cfg_d;
  logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;

  logic [N_CH-1:0]             ch_en;
  logic [N_CH-1:0][CNT_W-1:0]  ch_per;
  logic                        commit;
  logic                        pre_wrap;

  // The commit fires on the cycle after the last shift, when config_en has
  // just dropped.
  assign commit = cfg_q & ~config_en;

  // Decode the committed words. Channel 0 sits at the bs_in end of the chain.
  for (genvar k = 0; k < N_CH; k++) begin : g_decode
    assign ch_en[k]  = active_q[CHAIN_L-1-k*WORD_W];
    assign ch_per[k] = active_q[CHAIN_L-2-k*WORD_W -: CNT_W];
  end

`ifdef RETOSPECT_CLK_PRESCALE_EN
  logic [PRE_W-1:0] pre_q, pre_d;

  assign pre_wrap = (pre_q == active_q[PRE_W-1:0]);

  always_comb begin
    pre_d = pre_q;
    if (reset_nn || commit) begin
      pre_d = '0;
    end else if (!config_en) begin
      pre_d = pre_wrap ? '0 : pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end
`else
  assign pre_wrap = 1'b1;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    shadow_d = shadow_q;
    active_d = active_q;
    cfg_d    = config_en;
    cnt_d    = cnt_q;

    if (reset_nn) begin
      // A network reset wins over shifting: the chain holds for this cycle.
      cnt_d = '0;
    end else if (config_en) begin
      // The counters freeze while the chain shifts.
      shadow_d = {bs_in, shadow_q[CHAIN_L-1:1]};
    end else if (pre_wrap) begin
      for (int k = 0; k < N_CH; k++) begin
        if (!ch_en[k] || cnt_q[k] == ch_per[k]) cnt_d[k] = '0;
        else                                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end

    // A commit that coincides with reset_nn still commits.
    if (commit) begin
      active_d = shadow_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow chain is a plain register, not a RAM. It is reset so
      // that bs_out comes out of reset at a known 0 for the downstream CNBs.
      shadow_q <= '0;
      active_q <= '0;
      cfg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so that every flop
      // samples its pre-edge value.
      shadow_q <= shadow_d;
      active_q <= active_d;
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_tick
    assign clockbus[k+2] = ch_en[k] & (cnt_q[k] == ch_per[k]) & ~config_en & pre_wrap;
  end
  assign clockbus[1:0] = 2'b10;
  assign active_en     = ch_en;
  assign bs_out        = shadow_q[0];

endmodule

// File: tb/tb_retospect_clockbox_v2.sv
// -----------------------------------------------------------------------------
// Self-checking bench for retospect_clockbox_v2.
//
// Reference model:
//   - The chain is kept as a bit array.
//   - The committed configuration is kept as integers.
//   - Timing is a single count n of advancing cycles since the last clear.
//   - Channel k ticks when n mod ((per+1)*(pre+1)) == (per+1)*(pre+1)-1.
// -----------------------------------------------------------------------------
module tb_retospect_clockbox_v2;

  localparam int N_CH   = 6;
  localparam int CNT_W  = 8;
  localparam int PRE_W  = 4;
  localparam int WORD_W = CNT_W + 1;
`ifdef RETOSPECT_CLK_PRESCALE_EN
  localparam int PRE_EN = 1;
`else
  localparam int PRE_EN = 0;
`endif
  localparam int L = N_CH * WORD_W + PRE_EN * PRE_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            config_en;
  logic            bs_in;
  logic            bs_out;
  logic            reset_nn;
  logic [N_CH+1:0] clockbus;
  logic [N_CH-1:0] active_en;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  retospect_clockbox_v2 #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .config_en (config_en),
    .bs_in     (bs_in),
    .bs_out    (bs_out),
    .reset_nn  (reset_nn),
    .clockbus  (clockbus),
    .active_en (active_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit     m_chain [L];   // index 0 = just shifted in from bs_in, L-1 = bs_out
  bit     m_en    [N_CH];
  int     m_per   [N_CH];
  int     m_pre   = 0;
  longint m_n     = 0;
  bit     m_cfgd  = 1'b0;
  bit     m_commit;

  initial begin
    foreach (m_chain[i]) m_chain[i] = 1'b0;
    foreach (m_en[k]) begin
      m_en[k]  = 1'b0;
      m_per[k] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_chain[i]) m_chain[i] = 1'b0;
      foreach (m_en[k]) begin
        m_en[k]  = 1'b0;
        m_per[k] = 0;
      end
      m_pre  = 0;
      m_n    = 0;
      m_cfgd = 1'b0;
    end else begin
      m_commit = m_cfgd && !config_en;
      if (m_commit) begin
        for (int k = 0; k < N_CH; k++) begin
          m_en[k]  = m_chain[k*WORD_W];
          m_per[k] = 0;
          for (int j = 0; j < CNT_W; j++) m_per[k] = m_per[k] * 2 + int'(m_chain[k*WORD_W+1+j]);
        end
        m_pre = 0;
        if (PRE_EN != 0)
          for (int j = 0; j < PRE_W; j++) m_pre = m_pre * 2 + int'(m_chain[N_CH*WORD_W+j]);
      end
      if (reset_nn || m_commit) begin
        m_n = 0;
      end else if (config_en) begin
        for (int i = L - 1; i > 0; i--) m_chain[i] = m_chain[i-1];
        m_chain[0] = bs_in;
      end else begin
        m_n++;
      end
      m_cfgd = config_en;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [N_CH+1:0] exp_cb;
    logic [N_CH-1:0] exp_ae;
    longint          p;
    exp_cb = '0;
    exp_cb[1] = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      p = longint'(m_per[k] + 1) * longint'(m_pre + 1);
      exp_cb[k+2] = m_en[k] && !config_en && (m_n % p == p - 1);
      exp_ae[k]   = m_en[k];
    end
    check("model_clockbus", 64'(clockbus), 64'(exp_cb));
    check("model_active_en", 64'(active_en), 64'(exp_ae));
    check("model_bs_out", 64'(bs_out), 64'(m_chain[L-1]));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  bit cfg_en  [N_CH];
  int cfg_per [N_CH];
  int cfg_pre;

  task automatic drive(input bit ce, input bit b, input bit rn);
    @(posedge clk);
    #1;
    config_en = ce;
    bs_in     = b;
    reset_nn  = rn;
  endtask

  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  // Shifts the cfg_* image into the chain, then drops config_en.
  // e returns the commit cycle.
  task automatic program_cfg(output int e);
    bit img [L];
    for (int k = 0; k < N_CH; k++) begin
      img[k*WORD_W] = cfg_en[k];
      for (int j = 0; j < CNT_W; j++) img[k*WORD_W+1+j] = bit'((cfg_per[k] >> (CNT_W - 1 - j)) & 1);
    end
    for (int j = 0; j < PRE_EN * PRE_W; j++) img[N_CH*WORD_W+j] = bit'((cfg_pre >> (PRE_W - 1 - j)) & 1);
    for (int i = L - 1; i >= 0; i--) drive(1'b1, img[i], 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    e = cyc;
  endtask

  task automatic clear_cfg();
    foreach (cfg_en[k]) begin
      cfg_en[k]  = 1'b0;
      cfg_per[k] = 0;
    end
    cfg_pre = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int e;
  bit pat [70];
  int r;
  int nb;

  initial begin
    rst_n     = 1'b0;
    config_en = 1'b0;
    bs_in     = 1'b0;
    reset_nn  = 1'b0;
    @(negedge clk);
    check("reset_clockbus", 64'(clockbus), 64'h02);
    check("reset_bs_out", 64'(bs_out), 64'h0);
    check("reset_active_en", 64'(active_en), 64'h0);
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Single channel: ch0 period 3.
    clear_cfg();
    cfg_en[0]  = 1'b1;
    cfg_per[0] = 3;
    program_cfg(e);
    at_cycle(e + 3);
    check("ch0_no_tick_E+3", 64'(clockbus[2]), 64'h0);
    at_cycle(e + 4);
    check("ch0_tick_E+4", 64'(clockbus), 64'h06);
    at_cycle(e + 8);
    check("ch0_tick_E+8", 64'(clockbus[2]), 64'h1);
    at_cycle(e + 12);
    check("ch0_tick_E+12", 64'(clockbus[2]), 64'h1);

    // reset_nn pulse while the count is 2 (cycle E+15).
    at_cycle(e + 14);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    at_cycle(e + 18);
    check("reset_nn_no_tick", 64'(clockbus[2]), 64'h0);
    at_cycle(e + 19);
    check("reset_nn_tick_+4", 64'(clockbus[2]), 64'h1);

    // Asynchronous reset mid-count.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clockbus", 64'(clockbus), 64'h02);
    check("async_bs_out", 64'(bs_out), 64'h0);
    check("async_active_en", 64'(active_en), 64'h0);
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (20) drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("post_reset_idle", 64'(clockbus), 64'h02);

    // Boundary periods: ch1 period 0, ch2 period 255.
    clear_cfg();
    cfg_en[1]  = 1'b1;
    cfg_per[1] = 0;
    cfg_en[2]  = 1'b1;
    cfg_per[2] = 255;
    program_cfg(e);
    at_cycle(e + 1);
    check("per0_E+1", 64'(clockbus[3]), 64'h1);
    at_cycle(e + 2);
    check("per0_E+2", 64'(clockbus[3]), 64'h1);
    at_cycle(e + 255);
    check("per255_no_tick", 64'(clockbus[4]), 64'h0);
    at_cycle(e + 256);
    check("per255_tick1", 64'(clockbus[4]), 64'h1);
    at_cycle(e + 512);
    check("per255_tick2", 64'(clockbus[4]), 64'h1);
    at_cycle(e + 768);
    check("per255_tick3", 64'(clockbus[4]), 64'h1);

    // Chain passthrough: bs_out is bs_in delayed L cycles, and the config
    // stays frozen while the pattern shifts.
    foreach (pat[i]) pat[i] = bit'($urandom_range(0, 1));
    for (int i = 0; i < 70; i++) begin
      drive(1'b1, pat[i], 1'b0);
      @(negedge clk);
      if (i >= L) check("passthrough_bs_out", 64'(bs_out), 64'(pat[i-L]));
      check("shift_ticks_low", 64'(clockbus), 64'h02);
      check("shift_active_held", 64'(active_en), 64'h06);
    end
    drive(1'b0, 1'b0, 1'b0);

`ifdef RETOSPECT_CLK_PRESCALE_EN
    // Prescaler: pre=2 and ch0 period 1 give a 6-cycle tick.
    clear_cfg();
    cfg_en[0]  = 1'b1;
    cfg_per[0] = 1;
    cfg_pre    = 2;
    program_cfg(e);
    at_cycle(e + 5);
    check("pre_no_tick", 64'(clockbus[2]), 64'h0);
    at_cycle(e + 6);
    check("pre_tick1", 64'(clockbus[2]), 64'h1);
    at_cycle(e + 12);
    check("pre_tick2", 64'(clockbus[2]), 64'h1);
`endif

    // Randomised phase, checked by the model.
    for (int round = 0; round < 25; round++) begin
      for (int k = 0; k < N_CH; k++) begin
        cfg_en[k]  = bit'($urandom_range(0, 1));
        cfg_per[k] = int'($urandom_range(0, 9));
      end
      cfg_pre = PRE_EN * int'($urandom_range(0, 3));
      program_cfg(e);
      for (int c = 0; c < 150; c++) begin
        r = int'($urandom_range(0, 99));
        if (r < 4) begin
          drive(1'b0, 1'b0, 1'b1);
        end else if (r < 7) begin
          nb = int'($urandom_range(1, 5));
          for (int b = 0; b < nb; b++)
            drive(1'b1, bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
          drive(1'b0, 1'b0, 1'b0);
        end else if (r < 8) begin
          @(posedge clk);
          #1;
          rst_n = 1'b0;
          drive(1'b0, 1'b0, 1'b0);
          rst_n = 1'b1;
        end else begin
          drive(1'b0, 1'b0, 1'b0);
        end
      end
    end

    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
